lib_voq_islip_alloc: RTL and testbench

- Switch allocator for an input-queued router built from per-input virtual output queues (VOQs).
- Each cycle it takes the N×M VOQ valid matrix and downstream output readiness, and computes a conflict-free input/output match using single-iteration iSLIP (round-robin grant, then round-robin accept).
- Registered grants drive the VOQ read enables, one-hot per input.
- Per-output select indices drive the crossbar multiplexers.

---
 rtl/lib_voq_islip_alloc_pkg.sv | 13 +
 rtl/lib_voq_islip_alloc_rr_arbiter.sv | 32 +++
 rtl/lib_voq_islip_alloc.sv | 103 ++++++++++
 tb/tb_lib_voq_islip_alloc.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/lib_voq_islip_alloc_pkg.sv
// Shared helpers for the VOQ iSLIP allocator: index widths and wrap-around pointer increment.
package lib_voq_islip_alloc_pkg;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Explicit wrap so non-power-of-two port counts never rely on natural overflow.
    function automatic int wrap_inc(input int idx, input int modulus);
        return (idx + 1 >= modulus) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/lib_voq_islip_alloc_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first requester at or after ptr.
module lib_rr_arbiter
    import lib_voq_islip_alloc_pkg::*;
#(
    parameter int W     = 4,
    parameter int PTR_W = idx_w(W)
) (
    input  logic [0:W-1]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [0:W-1]     gnt
);

    // Two passes: positions at/after ptr first, then the wrapped positions below ptr.
    always_comb begin
        logic found;
        gnt   = '0;
        found = 1'b0;
        for (int i = 0; i < W; i++) begin
            if (!found && req[i] && (i >= int'(ptr))) begin
                gnt[i] = 1'b1;
                found  = 1'b1;
            end
        end
        for (int i = 0; i < W; i++) begin
            if (!found && req[i] && (i < int'(ptr))) begin
                gnt[i] = 1'b1;
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lib_voq_islip_alloc.sv
// Single-iteration iSLIP switch allocator for an N x M VOQ input-queued router.
module lib_voq_islip_alloc
    import lib_voq_islip_alloc_pkg::*;
#(
    parameter int N     = 5,
    parameter int M     = 5,
    parameter int SEL_W = idx_w(N)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    ce,
    input  logic [0:N-1][0:M-1]     i_req,
    input  logic [0:M-1]            i_out_rdy,
    output logic [0:N-1][0:M-1]     o_grant,
    output logic [0:M-1][SEL_W-1:0] o_sel,
    output logic [0:M-1]            o_sel_val
);

    localparam int ACC_W = idx_w(M);

    logic [0:N-1]            out_req_p0 [M];
    logic [0:N-1]            out_gnt_p0 [M];
    logic [0:M-1]            in_req_p0  [N];
    logic [0:M-1]            match_p0   [N];
    logic [0:M-1][SEL_W-1:0] gptr, gptr_next;
    logic [0:N-1][ACC_W-1:0] aptr, aptr_next;
    logic [0:N-1][0:M-1]     grant_next;
    logic [0:M-1][SEL_W-1:0] sel_next;
    logic [0:M-1]            val_next;

    // The pair granted last cycle is popping now, so its VOQ valid is stale.
    always_comb begin
        for (int j = 0; j < M; j++) begin
            out_req_p0[j] = '0;
            for (int i = 0; i < N; i++) begin
                out_req_p0[j][i] = i_req[i][j] & i_out_rdy[j] & ~o_grant[i][j];
            end
        end
    end

    for (genvar j = 0; j < M; j++) begin : g_grant_arb
        lib_rr_arbiter #(.W(N), .PTR_W(SEL_W)) u_grant (
            .req (out_req_p0[j]),
            .ptr (gptr[j]),
            .gnt (out_gnt_p0[j])
        );
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            in_req_p0[i] = '0;
            for (int j = 0; j < M; j++) begin
                in_req_p0[i][j] = out_gnt_p0[j][i];
            end
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_accept_arb
        lib_rr_arbiter #(.W(M), .PTR_W(ACC_W)) u_accept (
            .req (in_req_p0[i]),
            .ptr (aptr[i]),
            .gnt (match_p0[i])
        );
    end

    // Only accepted pairs move pointers; rejected grants leave g[j] alone.
    always_comb begin
        gptr_next  = gptr;
        aptr_next  = aptr;
        grant_next = '0;
        sel_next   = '0;
        val_next   = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < M; j++) begin
                if (match_p0[i][j]) begin
                    grant_next[i][j] = 1'b1;
                    gptr_next[j]     = SEL_W'(wrap_inc(i, N));
                    aptr_next[i]     = ACC_W'(wrap_inc(j, M));
                    sel_next[j]      = SEL_W'(i);
                    val_next[j]      = 1'b1;
                end
            end
        end
    end

    // ---- stage boundary: match registered to VOQ read enables and crossbar selects ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_grant   <= '0;
            o_sel     <= '0;
            o_sel_val <= '0;
            gptr      <= '0;
            aptr      <= '0;
        end else if (ce) begin
            o_grant   <= grant_next;
            o_sel     <= sel_next;
            o_sel_val <= val_next;
            gptr      <= gptr_next;
            aptr      <= aptr_next;
        end
    end

endmodule

// File: tb/tb_lib_voq_islip_alloc.sv
// Directed scoreboard bench for lib_voq_islip_alloc (N=M=5) with hand-computed grant sequences.
module tb_lib_voq_islip_alloc;

    typedef logic [0:4][0:4] mat_t;
    typedef logic [0:4][2:0] sel_t;
    typedef struct {
        mat_t  g;
        string name;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       ce;
    mat_t       i_req;
    logic [0:4] i_out_rdy;
    mat_t       o_grant;
    sel_t       o_sel;
    logic [0:4] o_sel_val;

    exp_t q[$];
    int   checks;
    int   errors;

    lib_voq_islip_alloc #(.N(5), .M(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .ce        (ce),
        .i_req     (i_req),
        .i_out_rdy (i_out_rdy),
        .o_grant   (o_grant),
        .o_sel     (o_sel),
        .o_sel_val (o_sel_val)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic mat_t pair(input int i, input int j);
        mat_t v;
        v = '0;
        v[i][j] = 1'b1;
        return v;
    endfunction

    function automatic sel_t exp_sel(input mat_t g);
        sel_t s;
        s = '0;
        for (int j = 0; j < 5; j++)
            for (int i = 0; i < 5; i++)
                if (g[i][j]) s[j] = 3'(i);
        return s;
    endfunction

    function automatic logic [0:4] exp_val(input mat_t g);
        logic [0:4] v;
        v = '0;
        for (int j = 0; j < 5; j++)
            for (int i = 0; i < 5; i++)
                if (g[i][j]) v[j] = 1'b1;
        return v;
    endfunction

    // Monitor: the DUT presents a registered match after every active edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            checks++;
            if (o_grant !== e.g) begin
                errors++;
                $display("FAIL %s grant got=%h want=%h", e.name, o_grant, e.g);
            end
            checks++;
            if (o_sel !== exp_sel(e.g)) begin
                errors++;
                $display("FAIL %s sel got=%h want=%h", e.name, o_sel, exp_sel(e.g));
            end
            checks++;
            if (o_sel_val !== exp_val(e.g)) begin
                errors++;
                $display("FAIL %s sel_val got=%b want=%b", e.name, o_sel_val, exp_val(e.g));
            end
        end
    end

    task automatic check_zero(input string nm);
        checks++;
        if (o_grant !== '0 || o_sel !== '0 || o_sel_val !== '0) begin
            errors++;
            $display("FAIL %s reset outputs got grant=%h sel=%h val=%b want all zero",
                     nm, o_grant, o_sel, o_sel_val);
        end
    endtask

    // Reset asserted and released between clock edges; clearing is checked before any edge.
    task automatic do_reset(input string nm);
        @(negedge clk);
        i_req     = '0;
        i_out_rdy = '1;
        ce        = 1'b1;
        reset     = 1'b1;
        #1;
        check_zero(nm);
        #2;
        reset = 1'b0;
    endtask

    task automatic step(input mat_t req, input logic [0:4] rdy, input logic ce_v,
                        input mat_t eg, input string nm);
        exp_t e;
        @(negedge clk);
        i_req     = req;
        i_out_rdy = rdy;
        ce        = ce_v;
        e.g       = eg;
        e.name    = nm;
        q.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout pending=%0d", q.size());
        $fatal(1);
    end

    initial begin
        mat_t z, f13, c2, t3, perm;
        logic [0:4] all_rdy, rdy_no2;
        checks    = 0;
        errors    = 0;
        z         = '0;
        all_rdy   = 5'b11111;
        rdy_no2   = 5'b11011;
        f13       = pair(1, 3);
        c2        = pair(0, 2) | pair(2, 2) | pair(4, 2);
        t3        = pair(0, 1) | pair(0, 3);
        perm      = pair(0, 1) | pair(1, 2) | pair(2, 3) | pair(3, 4) | pair(4, 0);

        reset     = 1'b1;
        ce        = 1'b1;
        i_req     = '0;
        i_out_rdy = '1;
        #1;
        check_zero("reset_init");
        @(negedge clk);
        #1 reset = 1'b0;

        // 1: single flow, pair mask makes grants every other cycle
        do_reset("reset_t1");
        step(f13, all_rdy, 1'b1, pair(1, 3), "t1_c0");
        step(f13, all_rdy, 1'b1, z,          "t1_c1");
        step(f13, all_rdy, 1'b1, pair(1, 3), "t1_c2");
        step(f13, all_rdy, 1'b1, z,          "t1_c3");

        // 2: output contention, rotation 0,2,4,0,2
        do_reset("reset_t2");
        step(c2, all_rdy, 1'b1, pair(0, 2), "t2_c0");
        step(c2, all_rdy, 1'b1, pair(2, 2), "t2_c1");
        step(c2, all_rdy, 1'b1, pair(4, 2), "t2_c2");
        step(c2, all_rdy, 1'b1, pair(0, 2), "t2_c3");
        step(c2, all_rdy, 1'b1, pair(2, 2), "t2_c4");

        // 3: input contention, accepts alternate 1,3
        do_reset("reset_t3");
        step(t3, all_rdy, 1'b1, pair(0, 1), "t3_c0");
        step(t3, all_rdy, 1'b1, pair(0, 3), "t3_c1");
        step(t3, all_rdy, 1'b1, pair(0, 1), "t3_c2");
        step(t3, all_rdy, 1'b1, pair(0, 3), "t3_c3");

        // 4: permutation, full match in one cycle then all masked
        do_reset("reset_t4");
        step(perm, all_rdy, 1'b1, perm, "t4_c0");
        step(perm, all_rdy, 1'b1, z,    "t4_c1");

        // 5: backpressure on output 2, rotation resumes at input 2
        do_reset("reset_t5");
        step(c2, all_rdy, 1'b1, pair(0, 2), "t5_c0");
        step(c2, rdy_no2, 1'b1, z,          "t5_c1");
        step(c2, rdy_no2, 1'b1, z,          "t5_c2");
        step(c2, rdy_no2, 1'b1, z,          "t5_c3");
        step(c2, all_rdy, 1'b1, pair(2, 2), "t5_c4");
        step(c2, all_rdy, 1'b1, pair(4, 2), "t5_c5");

        // 6: ce low freezes outputs and pointers, then mid-stream reset
        do_reset("reset_t6");
        step(c2, all_rdy, 1'b1, pair(0, 2), "t6_c0");
        step(c2, all_rdy, 1'b0, pair(0, 2), "t6_hold0");
        step(c2, all_rdy, 1'b0, pair(0, 2), "t6_hold1");
        step(c2, all_rdy, 1'b1, pair(2, 2), "t6_c1");
        do_reset("reset_t6_mid");
        step(c2, all_rdy, 1'b1, pair(0, 2), "t6_after_rst");
        step(z,  all_rdy, 1'b1, z,          "t6_idle");

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain pending got=%0d want=0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
